// File: rtl/brew_sequencer.sv
// brew_sequencer
// Table-driven beverage sequencer. A latched recipe runs through the
// HEAT -> COFFEE -> MILK -> FOAM phases. Each phase lasts a per-recipe number
// of seconds, and a phase whose duration is zero is skipped. The run ends with
// a DONE hold before the sequencer returns to IDLE. The 1 s time base is an
// internal tick enable derived from clk; no derived clock is generated.
//
// Optional feature macro: BREW_PAUSE_EN
//   When defined, pause freezes the tick counter, secs_left and the phase
//   while a brew phase is active. When undefined, the pause pin is ignored.
module brew_sequencer #(
  parameter int NUM_RECIPES = 4,
  parameter int SEL_W       = $clog2(NUM_RECIPES),
  parameter int TICK_DIV    = 50_000_000,
  parameter int PHASE_W     = 4,
  parameter int DONE_HOLD   = 5,
  parameter logic [NUM_RECIPES*4*PHASE_W-1:0] RECIPE_TBL =
    (NUM_RECIPES*4*PHASE_W)'(64'h0604_2333_0423_0053)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               cancel,
  input  logic [SEL_W-1:0]   recipe_sel,
  input  logic               pause,
  output logic [2:0]         phase,
  output logic [SEL_W-1:0]   recipe,
  output logic [PHASE_W-1:0] secs_left,
  output logic               busy,
  output logic               done,
  output logic               done_pulse,
  output logic               err_pulse,
  output logic               abort_pulse
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int NSEL  = 2 ** SEL_W;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_HEAT   = 3'd1,
    PH_COFFEE = 3'd2,
    PH_MILK   = 3'd3,
    PH_FOAM   = 3'd4,
    PH_DONE   = 3'd5
  } phase_e;

  // One recipe row: slot 0 = HEAT ... slot 3 = FOAM.
  typedef logic [3:0][PHASE_W-1:0] durs_t;

  // The table is zero-extended to every encodable selector value. Rows past
  // NUM_RECIPES then read as all-zero and are never reachable, because an
  // out-of-range selector is rejected before it is latched.
  localparam logic [NSEL-1:0][3:0][PHASE_W-1:0] TBL_EXT =
    (NSEL*4*PHASE_W)'(RECIPE_TBL);

  // Marks which selector encodings name a real recipe.
  function automatic logic [NSEL-1:0] sel_ok_mask();
    logic [NSEL-1:0] m;
    m = {NSEL{1'b0}};
    for (int i = 0; i < NSEL; i++) begin
      m[i] = (i < NUM_RECIPES);
    end
    return m;
  endfunction

  localparam logic [NSEL-1:0] SEL_OK = sel_ok_mask();

  // Returns the first phase at or after from_slot that has a non-zero
  // duration, or DONE when no such phase remains. The loop runs downward so
  // that the lowest qualifying slot is the one that sticks.
  function automatic phase_e pick_phase(input durs_t d, input logic [2:0] from_slot);
    phase_e ph;
    ph = PH_DONE;
    for (int i = 3; i >= 0; i--) begin
      if ((3'(i) >= from_slot) && (d[i[1:0]] != {PHASE_W{1'b0}})) begin
        ph = phase_e'(3'(i) + 3'd1);
      end
    end
    return ph;
  endfunction

  // Seconds loaded when the sequencer enters phase ph.
  function automatic logic [PHASE_W-1:0] load_secs(input durs_t d, input phase_e ph);
    logic [PHASE_W-1:0] s;
    case (ph)
      PH_HEAT:   s = d[2'd0];
      PH_COFFEE: s = d[2'd1];
      PH_MILK:   s = d[2'd2];
      PH_FOAM:   s = d[2'd3];
      PH_DONE:   s = PHASE_W'(DONE_HOLD);
      default:   s = {PHASE_W{1'b0}};
    endcase
    return s;
  endfunction

  phase_e             phase_r, phase_n;
  logic [SEL_W-1:0]   recipe_r, recipe_n;
  logic [PHASE_W-1:0] secs_r, secs_n;
  logic               busy_r, busy_n;
  logic               done_r, done_n;
  logic               done_pulse_r, done_pulse_n;
  logic               err_pulse_r, err_pulse_n;
  logic               abort_pulse_r, abort_pulse_n;
  logic [CNT_W-1:0]   cnt_r;

  durs_t  sel_durs_s;
  durs_t  cur_durs_s;
  phase_e first_ph_s;
  phase_e next_ph_s;
  logic   sel_valid_s;
  logic   accept_s;
  logic   tick_raw_s;
  logic   tick_s;
  logic   pause_hold_s;

  assign sel_durs_s  = TBL_EXT[recipe_sel];
  assign cur_durs_s  = TBL_EXT[recipe_r];
  assign sel_valid_s = SEL_OK[recipe_sel];
  assign first_ph_s  = pick_phase(sel_durs_s, 3'd0);
  // An active phase code c (1..4) resumes the search at slot c, i.e. the
  // slot right after its own.
  assign next_ph_s   = pick_phase(cur_durs_s, phase_r);

  assign accept_s    = (phase_r == PH_IDLE) && start && !cancel && sel_valid_s;
  assign tick_raw_s  = (cnt_r == CNT_W'(TICK_DIV - 1));
  assign tick_s      = tick_raw_s && !pause_hold_s;

`ifdef BREW_PAUSE_EN
  assign pause_hold_s = busy_r && pause;
`else
  // The pause pin is kept for pin compatibility but has no effect in this
  // build.
  assign pause_hold_s = pause & 1'b0;
`endif

  // 1 s time base. The count restarts on accept so that the first second of
  // a brew is a full second.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (pause_hold_s) begin
      cnt_r <= cnt_r;
    end else if (tick_raw_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Next-state, countdown and pulse generation.
  always_comb begin
    phase_n       = phase_r;
    recipe_n      = recipe_r;
    secs_n        = secs_r;
    err_pulse_n   = 1'b0;
    abort_pulse_n = 1'b0;
    case (phase_r)
      PH_IDLE: begin
        if (start && !cancel) begin
          if (sel_valid_s) begin
            recipe_n = recipe_sel;
            phase_n  = first_ph_s;
            secs_n   = load_secs(sel_durs_s, first_ph_s);
          end else begin
            err_pulse_n = 1'b1;
          end
        end else begin
          phase_n = PH_IDLE;
        end
      end
      PH_HEAT, PH_COFFEE, PH_MILK, PH_FOAM: begin
        if (cancel) begin
          phase_n       = PH_IDLE;
          secs_n        = {PHASE_W{1'b0}};
          abort_pulse_n = 1'b1;
        end else if (tick_s) begin
          if (secs_r <= PHASE_W'(1)) begin
            phase_n = next_ph_s;
            secs_n  = load_secs(cur_durs_s, next_ph_s);
          end else begin
            secs_n = secs_r - PHASE_W'(1);
          end
        end else begin
          secs_n = secs_r;
        end
      end
      PH_DONE: begin
        if (cancel) begin
          phase_n = PH_IDLE;
          secs_n  = {PHASE_W{1'b0}};
        end else if (tick_s) begin
          if (secs_r <= PHASE_W'(1)) begin
            phase_n = PH_IDLE;
            secs_n  = {PHASE_W{1'b0}};
          end else begin
            secs_n = secs_r - PHASE_W'(1);
          end
        end else begin
          secs_n = secs_r;
        end
      end
      default: begin
        phase_n = PH_IDLE;
        secs_n  = {PHASE_W{1'b0}};
      end
    endcase

    busy_n       = (phase_n == PH_HEAT) || (phase_n == PH_COFFEE) ||
                   (phase_n == PH_MILK) || (phase_n == PH_FOAM);
    done_n       = (phase_n == PH_DONE);
    done_pulse_n = (phase_n == PH_DONE) && (phase_r != PH_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r       <= PH_IDLE;
      recipe_r      <= {SEL_W{1'b0}};
      secs_r        <= {PHASE_W{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      done_pulse_r  <= 1'b0;
      err_pulse_r   <= 1'b0;
      abort_pulse_r <= 1'b0;
    end else begin
      phase_r       <= phase_n;
      recipe_r      <= recipe_n;
      secs_r        <= secs_n;
      busy_r        <= busy_n;
      done_r        <= done_n;
      done_pulse_r  <= done_pulse_n;
      err_pulse_r   <= err_pulse_n;
      abort_pulse_r <= abort_pulse_n;
    end
  end

  assign phase       = phase_r;
  assign recipe      = recipe_r;
  assign secs_left   = secs_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign done_pulse  = done_pulse_r;
  assign err_pulse   = err_pulse_r;
  assign abort_pulse = abort_pulse_r;

endmodule

// File: tb/tb_brew_sequencer.sv
// tb_brew_sequencer
// Directed bench for brew_sequencer with TICK_DIV=4. The main instance runs
// the default 4-recipe table. A second instance with NUM_RECIPES=3 exercises
// rejection of an out-of-range selector. Expected values are hand-derived
// cycle offsets, counted from the cycle in which start was presented.
module tb_brew_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       cancel;
  logic       pause;
  logic [1:0] recipe_sel;
  logic [2:0] phase;
  logic [1:0] recipe;
  logic [3:0] secs_left;
  logic       busy, done, done_pulse, err_pulse, abort_pulse;

  logic       start3;
  logic [1:0] sel3;
  logic [2:0] phase3;
  logic [1:0] recipe3;
  logic [3:0] secs3;
  logic       busy3, done3, dp3, ep3, ap3;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;
  bit seen_coffee;

  brew_sequencer #(.NUM_RECIPES(4), .TICK_DIV(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .cancel(cancel),
    .recipe_sel(recipe_sel), .pause(pause), .phase(phase), .recipe(recipe),
    .secs_left(secs_left), .busy(busy), .done(done), .done_pulse(done_pulse),
    .err_pulse(err_pulse), .abort_pulse(abort_pulse)
  );

  brew_sequencer #(.NUM_RECIPES(3), .TICK_DIV(4),
                   .RECIPE_TBL(48'h2333_0423_0053)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .cancel(cancel),
    .recipe_sel(sel3), .pause(pause), .phase(phase3), .recipe(recipe3),
    .secs_left(secs3), .busy(busy3), .done(done3), .done_pulse(dp3),
    .err_pulse(ep3), .abort_pulse(ap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to cycle offset n; values are sampled 1 ns after the edge.
  task automatic go_to(input int n);
    while (t < n) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  // Present start for exactly one cycle (cycle N); on return we are in N+1.
  task automatic do_start(input logic [1:0] sel);
    start      = 1'b1;
    recipe_sel = sel;
    @(posedge clk);
    #1;
    start = 1'b0;
    t     = 1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cancel = 1'b0; pause = 1'b0; recipe_sel = 2'd0;
    start3 = 1'b0; sel3 = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_phase", 32'(phase), 32'd0);
    check_eq("rst_recipe", 32'(recipe), 32'd0);
    check_eq("rst_secs", 32'(secs_left), 32'd0);
    check_eq("rst_flags", 32'({busy, done, done_pulse, err_pulse, abort_pulse}), 32'd0);

    // Espresso: HEAT 3 s, COFFEE 5 s.
    do_start(2'd0);
    check_eq("esp_heat", 32'(phase), 32'd1);
    check_eq("esp_heat_secs", 32'(secs_left), 32'd3);
    check_eq("esp_busy", 32'(busy), 32'd1);
    go_to(5);
    start = 1'b1; recipe_sel = 2'd1;
    go_to(6);
    start = 1'b0;
    check_eq("busy_start_recipe", 32'(recipe), 32'd0);
    check_eq("busy_start_secs", 32'(secs_left), 32'd2);
    go_to(12);
    check_eq("esp_heat_last", 32'(phase), 32'd1);
    check_eq("esp_heat_last_secs", 32'(secs_left), 32'd1);
    go_to(13);
    check_eq("esp_coffee", 32'(phase), 32'd2);
    check_eq("esp_coffee_secs", 32'(secs_left), 32'd5);
    go_to(32);
    check_eq("esp_coffee_last", 32'(phase), 32'd2);
    go_to(33);
    check_eq("esp_done", 32'(phase), 32'd5);
    check_eq("esp_done_lvl", 32'({done, busy}), 32'b10);
    check_eq("esp_done_pulse", 32'(done_pulse), 32'd1);
    check_eq("esp_done_secs", 32'(secs_left), 32'd5);
    go_to(34);
    check_eq("esp_done_pulse_end", 32'(done_pulse), 32'd0);
    go_to(52);
    check_eq("esp_hold_last", 32'(secs_left), 32'd1);
    go_to(53);
    check_eq("esp_idle", 32'(phase), 32'd0);
    check_eq("esp_idle_flags", 32'({done, secs_left}), 32'd0);

    // Cappuccino: 3,3,3,2 s, then cancel while in DONE.
    do_start(2'd2);
    check_eq("cap_heat", 32'(phase), 32'd1);
    go_to(13);
    check_eq("cap_coffee", 32'({phase, secs_left}), 32'({3'd2, 4'd3}));
    go_to(25);
    check_eq("cap_milk", 32'({phase, secs_left}), 32'({3'd3, 4'd3}));
    go_to(37);
    check_eq("cap_foam", 32'({phase, secs_left}), 32'({3'd4, 4'd2}));
    go_to(44);
    check_eq("cap_foam_last", 32'(phase), 32'd4);
    go_to(45);
    check_eq("cap_done", 32'({phase, done_pulse}), 32'({3'd5, 1'b1}));
    go_to(46);
    cancel = 1'b1;
    go_to(47);
    cancel = 1'b0;
    check_eq("done_cancel_phase", 32'({phase, secs_left}), 32'd0);
    check_eq("done_cancel_no_abort", 32'(abort_pulse), 32'd0);

    // Recipe 3: HEAT 4 s then MILK 6 s; COFFEE must never appear.
    seen_coffee = 1'b0;
    do_start(2'd3);
    check_eq("skip_heat_secs", 32'(secs_left), 32'd4);
    while (t < 16) begin
      go_to(t + 1);
      if (phase == 3'd2) seen_coffee = 1'b1;
    end
    check_eq("skip_heat_last", 32'(phase), 32'd1);
    go_to(17);
    check_eq("skip_milk", 32'({phase, secs_left}), 32'({3'd3, 4'd6}));
    while (t < 41) begin
      go_to(t + 1);
      if (phase == 3'd2) seen_coffee = 1'b1;
    end
    check_eq("skip_done", 32'(phase), 32'd5);
    check_eq("skip_no_coffee", 32'(seen_coffee), 32'd0);
    go_to(61);
    check_eq("skip_idle", 32'(phase), 32'd0);

    // Cancel during cappuccino COFFEE at N+20.
    do_start(2'd2);
    go_to(20);
    cancel = 1'b1;
    go_to(21);
    cancel = 1'b0;
    check_eq("abort_phase", 32'({phase, secs_left}), 32'd0);
    check_eq("abort_pulse", 32'(abort_pulse), 32'd1);
    go_to(22);
    check_eq("abort_pulse_end", 32'(abort_pulse), 32'd0);

    // start together with cancel in IDLE: nothing accepted.
    start = 1'b1; cancel = 1'b1; recipe_sel = 2'd0;
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
    check_eq("start_cancel_phase", 32'(phase), 32'd0);
    check_eq("start_cancel_recipe", 32'(recipe), 32'd2);
    check_eq("start_cancel_err", 32'(err_pulse), 32'd0);

    // Out-of-range selector on the 3-recipe instance.
    start3 = 1'b1; sel3 = 2'd3;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    check_eq("inv_err", 32'(ep3), 32'd1);
    check_eq("inv_phase", 32'(phase3), 32'd0);
    @(posedge clk);
    #1;
    check_eq("inv_err_end", 32'({ep3, phase3}), 32'd0);
    start3 = 1'b1; cancel = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0; cancel = 1'b0;
    check_eq("inv_cancel_no_err", 32'(ep3), 32'd0);
    start3 = 1'b1; sel3 = 2'd2;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    check_eq("r3_valid", 32'({phase3, secs3, recipe3}), 32'({3'd1, 4'd3, 2'd2}));

    // Reset in the middle of recipe 1 (3,2,4,0).
    do_start(2'd1);
    go_to(13);
    check_eq("r1_coffee", 32'({phase, secs_left}), 32'({3'd2, 4'd2}));
    reset = 1'b1;
    go_to(14);
    reset = 1'b0;
    check_eq("midrst_state", 32'({phase, recipe, secs_left}), 32'd0);
    check_eq("midrst_flags", 32'({busy, done, done_pulse, err_pulse, abort_pulse}), 32'd0);

    // Espresso with pause held for 10 cycles during COFFEE.
    do_start(2'd0);
    go_to(15);
    pause = 1'b1;
    go_to(25);
    pause = 1'b0;
`ifdef BREW_PAUSE_EN
    go_to(42);
    check_eq("pause_coffee_last", 32'(phase), 32'd2);
    go_to(43);
    check_eq("pause_done", 32'({phase, done_pulse}), 32'({3'd5, 1'b1}));
`else
    go_to(32);
    check_eq("nopause_coffee_last", 32'(phase), 32'd2);
    go_to(33);
    check_eq("nopause_done", 32'({phase, done_pulse}), 32'({3'd5, 1'b1}));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
